oled_i2c_sequencer: RTL

- Command/data sequencer that sits directly upstream of the I2C master on the OLED path.
- After reset it waits a power-up delay, then issues the fixed 25-command SSD1306 128x64 init list, one I2C single-byte write per command.
- It then streams 1024-byte frames on request, taking bytes from a valid/ready pixel interface.
- It drives the master's enable/data_w/reg_addr/dev_addr/divider and paces itself purely on the master's busy output.

---
 rtl/oled_i2c_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/oled_i2c_sequencer.sv
// SSD1306 128x64 sequencer sitting in front of an I2C master: power-up delay,
// fixed init list, then 1024-byte frames from a valid/ready pixel port.
//   state     | meaning
//   M_POWERUP | wait the power-up delay and for the master to go idle
//   M_INIT    | send the fixed init command list
//   M_READY   | idle, waiting for frame_start
//   M_FADDR   | send the column/page window commands
//   M_FDATA   | stream pixel bytes with the data control byte
//   M_ERROR   | handshake timeout; parked until reset
module oled_i2c_sequencer #(
  parameter logic [6:0]  DEV_ADDR       = 7'h3C,
  parameter logic [15:0] I2C_DIVIDER    = 16'd124,
  parameter int          POWERUP_CYCLES = 100000,
  parameter int          TIMEOUT_CYCLES = 65535,
  parameter int          FRAME_BYTES    = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_start,
  input  logic        i_pix_valid,
  input  logic [7:0]  i_pix_data,
  output logic        o_pix_ready,
  output logic        o_init_done,
  output logic        o_frame_done,
  output logic        o_error,
  output logic        o_i2c_enable,
  output logic        o_i2c_read_write,
  output logic [7:0]  o_i2c_data_w,
  output logic [7:0]  o_i2c_reg_addr,
  output logic [6:0]  o_i2c_dev_addr,
  output logic [15:0] o_i2c_divider,
  input  logic        i_i2c_busy
);

  localparam int PW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam logic [PW-1:0] PWR_LAST  = PW'(POWERUP_CYCLES - 1);
  localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0]   BYTES_END = 11'(FRAME_BYTES);
  localparam logic [7:0]    CTRL_CMD  = 8'h00;
  localparam logic [7:0]    CTRL_DATA = 8'h40;

  typedef enum logic [2:0] {M_POWERUP, M_INIT, M_READY, M_FADDR, M_FDATA, M_ERROR} main_t;
  typedef enum logic [1:0] {X_IDLE, X_REQ, X_ACC, X_DONE} xfer_t;

  main_t          r_main;
  xfer_t          r_xfer;
  logic [PW-1:0]  r_pwr_cnt;
  logic [4:0]     r_init_idx;
  logic [2:0]     r_addr_idx;
  logic [10:0]    r_byte_cnt;
  logic [15:0]    r_to_cnt;
  logic           r_pix_ready;
  logic           r_init_done;
  logic           r_frame_done;
  logic           r_error;
  logic           r_enable;
  logic [7:0]     r_data_w;
  logic [7:0]     r_reg_addr;

  logic w_xfer_done;
  logic w_can_launch;
  logic w_to_hit;

  function automatic logic [7:0] f_init_cmd(input logic [4:0] idx);
    case (idx)
      5'd0:  f_init_cmd = 8'hAE;  5'd1:  f_init_cmd = 8'hD5;  5'd2:  f_init_cmd = 8'h80;
      5'd3:  f_init_cmd = 8'hA8;  5'd4:  f_init_cmd = 8'h3F;  5'd5:  f_init_cmd = 8'hD3;
      5'd6:  f_init_cmd = 8'h00;  5'd7:  f_init_cmd = 8'h40;  5'd8:  f_init_cmd = 8'h8D;
      5'd9:  f_init_cmd = 8'h14;  5'd10: f_init_cmd = 8'h20;  5'd11: f_init_cmd = 8'h00;
      5'd12: f_init_cmd = 8'hA1;  5'd13: f_init_cmd = 8'hC8;  5'd14: f_init_cmd = 8'hDA;
      5'd15: f_init_cmd = 8'h12;  5'd16: f_init_cmd = 8'h81;  5'd17: f_init_cmd = 8'hCF;
      5'd18: f_init_cmd = 8'hD9;  5'd19: f_init_cmd = 8'hF1;  5'd20: f_init_cmd = 8'hDB;
      5'd21: f_init_cmd = 8'h40;  5'd22: f_init_cmd = 8'hA4;  5'd23: f_init_cmd = 8'hA6;
      5'd24: f_init_cmd = 8'hAF;
      default: f_init_cmd = 8'h00;
    endcase
  endfunction

  // Full-screen window: columns 0..127, pages 0..7.
  function automatic logic [7:0] f_addr_cmd(input logic [2:0] idx);
    case (idx)
      3'd0: f_addr_cmd = 8'h21;  3'd1: f_addr_cmd = 8'h00;  3'd2: f_addr_cmd = 8'h7F;
      3'd3: f_addr_cmd = 8'h22;  3'd4: f_addr_cmd = 8'h00;  3'd5: f_addr_cmd = 8'h07;
      default: f_addr_cmd = 8'h00;
    endcase
  endfunction

  assign w_xfer_done  = (r_xfer == X_DONE) && !i_i2c_busy;
  assign w_can_launch = (r_xfer == X_IDLE) && !i_i2c_busy;
  assign w_to_hit     = (((r_xfer == X_ACC) && !i_i2c_busy) || ((r_xfer == X_DONE) && i_i2c_busy))
                        && (r_to_cnt == TO_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_main       <= M_POWERUP;
      r_xfer       <= X_IDLE;
      r_pwr_cnt    <= '0;
      r_init_idx   <= '0;
      r_addr_idx   <= '0;
      r_byte_cnt   <= '0;
      r_to_cnt     <= '0;
      r_pix_ready  <= 1'b0;
      r_init_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_error      <= 1'b0;
      r_enable     <= 1'b0;
      r_data_w     <= '0;
      r_reg_addr   <= '0;
    end else begin
      r_frame_done <= 1'b0;

      case (r_xfer)
        X_REQ: begin
          r_enable <= 1'b0;
          r_xfer   <= X_ACC;
          r_to_cnt <= '0;
        end
        X_ACC: begin
          if (i_i2c_busy) begin
            r_xfer   <= X_DONE;
            r_to_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        X_DONE: begin
          if (!i_i2c_busy) r_xfer   <= X_IDLE;
          else             r_to_cnt <= r_to_cnt + 1'b1;
        end
        default: ;
      endcase

      case (r_main)
        M_POWERUP: begin
          if (r_pwr_cnt == PWR_LAST) begin
            if (!i_i2c_busy) r_main <= M_INIT;
          end else begin
            r_pwr_cnt <= r_pwr_cnt + 1'b1;
          end
        end
        M_INIT: begin
          if (w_xfer_done) begin
            if (r_init_idx == 5'd24) begin
              r_init_done <= 1'b1;
              r_main      <= M_READY;
            end else begin
              r_init_idx <= r_init_idx + 1'b1;
            end
          end else if (w_can_launch) begin
            r_xfer     <= X_REQ;
            r_enable   <= 1'b1;
            r_data_w   <= f_init_cmd(r_init_idx);
            r_reg_addr <= CTRL_CMD;
          end
        end
        M_READY: begin
          if (i_frame_start) begin
            r_main     <= M_FADDR;
            r_addr_idx <= '0;
          end
        end
        M_FADDR: begin
          if (w_xfer_done) begin
            if (r_addr_idx == 3'd5) begin
              r_main      <= M_FDATA;
              r_byte_cnt  <= '0;
              r_pix_ready <= 1'b1;
            end else begin
              r_addr_idx <= r_addr_idx + 1'b1;
            end
          end else if (w_can_launch) begin
            r_xfer     <= X_REQ;
            r_enable   <= 1'b1;
            r_data_w   <= f_addr_cmd(r_addr_idx);
            r_reg_addr <= CTRL_CMD;
          end
        end
        M_FDATA: begin
          // pix_ready is re-armed only on the edge a byte's transaction ends
          if (w_xfer_done) begin
            if (r_byte_cnt == BYTES_END) begin
              r_frame_done <= 1'b1;
              r_main       <= M_READY;
            end else begin
              r_pix_ready <= 1'b1;
            end
          end else if (r_pix_ready && i_pix_valid) begin
            r_pix_ready <= 1'b0;
            r_byte_cnt  <= r_byte_cnt + 1'b1;
            r_xfer      <= X_REQ;
            r_enable    <= 1'b1;
            r_data_w    <= i_pix_data;
            r_reg_addr  <= CTRL_DATA;
          end
        end
        default: begin
          r_error     <= 1'b1;
          r_enable    <= 1'b0;
          r_pix_ready <= 1'b0;
        end
      endcase

      if (w_to_hit) begin
        r_main      <= M_ERROR;
        r_xfer      <= X_IDLE;
        r_error     <= 1'b1;
        r_enable    <= 1'b0;
        r_pix_ready <= 1'b0;
      end
    end
  end

  assign o_pix_ready      = r_pix_ready;
  assign o_init_done      = r_init_done;
  assign o_frame_done     = r_frame_done;
  assign o_error          = r_error;
  assign o_i2c_enable     = r_enable;
  assign o_i2c_read_write = 1'b0;
  assign o_i2c_data_w     = r_data_w;
  assign o_i2c_reg_addr   = r_reg_addr;
  assign o_i2c_dev_addr   = DEV_ADDR;
  assign o_i2c_divider    = I2C_DIVIDER;

endmodule
